// File: rtl/health_mon_pkg.sv
// Shared constants and types for the health-monitor datapath.
//   CLOCKS_PER_SECOND  : system clock rate in Hz
//   PULSE_COUNT_W      : width of a heart-beat count sample
//   BPM_WINDOW_SECONDS : length of the beat-counting window (BPM = count * 6)
package health_mon_pkg;

    localparam int unsigned CLOCKS_PER_SECOND  = 1_000_000;
    localparam int unsigned PULSE_COUNT_W      = 8;
    localparam int unsigned BPM_WINDOW_SECONDS = 10;

    typedef logic [PULSE_COUNT_W-1:0] pulse_count_t;

endpackage

// File: rtl/pulse_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous input.
// Ports:
//   clk    : sampling clock
//   rst_n  : asynchronous active-low reset
//   din    : raw input, asynchronous to clk
//   rise_c : one-cycle strobe (combinational) on a synchronized 0->1 transition
module pulse_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // s1/s2 resolve metastability, s3 holds the previous synchronized value
    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise_c = s2_q & ~s3_q;

endmodule

// File: rtl/pulse_window_counter.sv
// Heart-beat front end: conditions the raw sensor pulse, applies a refractory
// dead time, and counts accepted beats over a fixed window. At the end of each
// window the (saturating) count is published with a one-cycle valid strobe.
// Ports:
//   clk             : system clock
//   reset           : asynchronous active-low reset
//   enable          : synchronous measurement enable
//   pulse_in        : raw sensor pulse (asynchronous)
//   pulse_count     : beats in the last completed window
//   count_valid     : one-cycle strobe when pulse_count updates
//   count_saturated : last completed window clipped at 2^COUNT_W-1
//   pulse_seen      : one-cycle strobe per accepted beat
//   lead_off        : no-beat timeout flag
// Build option: define PULSE_LEAD_OFF_EN to include the lead-off timer;
// otherwise lead_off is tied low.
module pulse_window_counter #(
    parameter int unsigned CLOCKS_PER_SECOND = health_mon_pkg::CLOCKS_PER_SECOND,
    parameter int unsigned WINDOW_SECONDS    = health_mon_pkg::BPM_WINDOW_SECONDS,
    parameter int unsigned REFRACTORY_CYCLES = 200_000,
    parameter int unsigned COUNT_W           = health_mon_pkg::PULSE_COUNT_W,
    parameter int unsigned LEAD_OFF_SECONDS  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pulse_in,
    output logic [COUNT_W-1:0] pulse_count,
    output logic               count_valid,
    output logic               count_saturated,
    output logic               pulse_seen,
    output logic               lead_off
);

    localparam int unsigned WINDOW_CYCLES   = CLOCKS_PER_SECOND * WINDOW_SECONDS;
    localparam int unsigned WIN_W           = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned REF_W           = (REFRACTORY_CYCLES > 1) ? $clog2(REFRACTORY_CYCLES) : 1;
    localparam int unsigned LEAD_OFF_CYCLES = CLOCKS_PER_SECOND * LEAD_OFF_SECONDS;

    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [REF_W-1:0]   REF_LOAD  = REF_W'(REFRACTORY_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic rise_c;
    logic accept_c;

    logic [WIN_W-1:0]   win_q, win_d;
    logic [COUNT_W-1:0] acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [REF_W-1:0]   ref_q, ref_d;
    logic [COUNT_W-1:0] pulse_count_q, pulse_count_d;
    logic               sat_q, sat_d;
    logic               valid_q, valid_d;
    logic               seen_q, seen_d;

    pulse_edge_sync u_sync (
        .clk    (clk),
        .rst_n  (reset),
        .din    (pulse_in),
        .rise_c (rise_c)
    );

    assign accept_c = enable & rise_c & (ref_q == '0);

    // Window, accumulator, refractory and sample-publish next state
    always_comb begin
        win_d         = win_q;
        acc_d         = acc_q;
        ovf_d         = ovf_q;
        ref_d         = ref_q;
        pulse_count_d = pulse_count_q;
        sat_d         = sat_q;
        valid_d       = 1'b0;
        seen_d        = 1'b0;

        if (!enable) begin
            win_d = '0;
            acc_d = '0;
            ovf_d = 1'b0;
            ref_d = '0;
        end else begin
            seen_d = accept_c;

            if (accept_c) begin
                ref_d = REF_LOAD;
            end else if (ref_q != '0) begin
                ref_d = ref_q - 1'b1;
            end

            if (win_q == WIN_LAST) begin
                // A beat landing on the terminal cycle belongs to this window
                win_d         = '0;
                acc_d         = '0;
                ovf_d         = 1'b0;
                valid_d       = 1'b1;
                pulse_count_d = (accept_c && (acc_q != COUNT_MAX)) ? acc_q + 1'b1 : acc_q;
                sat_d         = ovf_q | (accept_c & (acc_q == COUNT_MAX));
            end else begin
                win_d = win_q + 1'b1;
                if (accept_c) begin
                    // ovf remembers that the true total went past the clip value
                    if (acc_q == COUNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = acc_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q         <= '0;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            ref_q         <= '0;
            pulse_count_q <= '0;
            sat_q         <= 1'b0;
            valid_q       <= 1'b0;
            seen_q        <= 1'b0;
        end else begin
            win_q         <= win_d;
            acc_q         <= acc_d;
            ovf_q         <= ovf_d;
            ref_q         <= ref_d;
            pulse_count_q <= pulse_count_d;
            sat_q         <= sat_d;
            valid_q       <= valid_d;
            seen_q        <= seen_d;
        end
    end

    assign pulse_count     = pulse_count_q;
    assign count_saturated = sat_q;
    assign count_valid     = valid_q;
    assign pulse_seen      = seen_q;

`ifdef PULSE_LEAD_OFF_EN
    localparam int unsigned      LO_W    = $clog2(LEAD_OFF_CYCLES + 1);
    localparam logic [LO_W-1:0]  LO_LAST = LO_W'(LEAD_OFF_CYCLES);

    logic [LO_W-1:0] lo_timer_q, lo_timer_d;
    logic            lead_off_q, lead_off_d;

    // No-beat timer saturates at the timeout; the flag mirrors its terminal value
    always_comb begin
        lo_timer_d = lo_timer_q;
        lead_off_d = lead_off_q;
        if (!enable || accept_c) begin
            lo_timer_d = '0;
        end else if (lo_timer_q != LO_LAST) begin
            lo_timer_d = lo_timer_q + 1'b1;
        end
        lead_off_d = (lo_timer_d == LO_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lo_timer_q <= '0;
            lead_off_q <= 1'b0;
        end else begin
            lo_timer_q <= lo_timer_d;
            lead_off_q <= lead_off_d;
        end
    end

    assign lead_off = lead_off_q;
`else
    // Timeout parameter still elaborated so both builds accept one parameter set
    assign lead_off = (LEAD_OFF_CYCLES == 0) && 1'b0;
`endif

endmodule
